// File: rtl/dc_sweep_sequencer_if.sv
// Bundled host, DAC, ADC and result-stream signals of the two-axis DC sweep sequencer.
// The slave modport is the sequencer itself; master is the host/environment side.
interface dc_sweep_sequencer_if #(
   parameter int DW = 12,
   parameter int AW = 16,
   parameter int NW = 8,
   parameter int SW = 16
) ();
   logic          start;
   logic          abort;
   logic [DW-1:0] g_start;
   logic [DW:0]   g_step;
   logic [NW-1:0] g_npts;
   logic [DW-1:0] d_start;
   logic [DW:0]   d_step;
   logic [NW-1:0] d_npts;
   logic [SW-1:0] settle_cyc;
   logic          bidir;
   logic [DW-1:0] vg_code;
   logic [DW-1:0] vd_code;
   logic          dac_upd;
   logic          adc_req;
   logic          adc_ack;
   logic [AW-1:0] adc_data;
   logic          res_valid;
   logic          res_ready;
   logic [AW-1:0] res_data;
   logic [NW-1:0] res_gi;
   logic [NW-1:0] res_di;
   logic          res_last;
   logic          busy;
   logic          done;
   logic          sat;

   modport slave (
      input  start, abort, g_start, g_step, g_npts, d_start, d_step, d_npts,
             settle_cyc, bidir, adc_ack, adc_data, res_ready,
      output vg_code, vd_code, dac_upd, adc_req, res_valid, res_data,
             res_gi, res_di, res_last, busy, done, sat
   );

   modport master (
      output start, abort, g_start, g_step, g_npts, d_start, d_step, d_npts,
             settle_cyc, bidir, adc_ack, adc_data, res_ready,
      input  vg_code, vd_code, dac_upd, adc_req, res_valid, res_data,
             res_gi, res_di, res_last, busy, done, sat
   );
endinterface

// File: rtl/dc_sweep_sequencer.sv
// Two-axis stepped DC sweep sequencer: gate (outer) x drain (inner) codes, settle wait,
// ADC request/ack, valid/ready result stream, optional forward-then-back inner sweep.
module dc_sweep_sequencer #(
   parameter int DW = 12,
   parameter int AW = 16,
   parameter int NW = 8,
   parameter int SW = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   dc_sweep_sequencer_if.slave bus
);

   localparam int CW = DW + 2;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] APPLY   = 3'd1;
   localparam logic [2:0] SETTLE  = 3'd2;
   localparam logic [2:0] MEAS    = 3'd3;
   localparam logic [2:0] EMIT    = 3'd4;
   localparam logic [2:0] ADVANCE = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   logic [2:0]           state_q, state_d;
   logic [DW:0]          gStep_q, gStep_d, dStep_q, dStep_d;
   logic [NW-1:0]        gNpts_q, gNpts_d, dNpts_q, dNpts_d;
   logic [NW:0]          innerLen_q, innerLen_d;
   logic [DW-1:0]        dStart_q, dStart_d;
   logic [SW-1:0]        settle_q, settle_d, cnt_q, cnt_d;
   logic signed [CW-1:0] gAcc_q, gAcc_d, dAcc_q, dAcc_d;
   logic [NW-1:0]        gi_q, gi_d;
   logic [NW:0]          di_q, di_d;
   logic                 first_q, first_d;
   logic [DW-1:0]        vg_q, vg_d, vd_q, vd_d;
   logic                 dacUpd_q, dacUpd_d;
   logic                 sat_q, sat_d;
   logic [AW-1:0]        resData_q, resData_d;
   logic [NW-1:0]        resGi_q, resGi_d, resDi_q, resDi_d;
   logic                 resLast_q, resLast_d;

   logic signed [CW-1:0] gStepX, dStepX;
   logic [NW-1:0]        gNEff, dNEff;
   logic [DW-1:0]        gCode, dCode;
   logic                 gClip, dClip, lastInner, lastOuter, innerFwd;

   // Accumulators are two bits wider than a code: the sign bit flags underflow, bit DW overflow.
   function automatic logic [DW-1:0] clampCode(input logic signed [CW-1:0] v);
      if (v[CW-1])      return '0;
      else if (v[DW])   return '1;
      else              return v[DW-1:0];
   endfunction

   assign gStepX    = {gStep_q[DW], gStep_q};
   assign dStepX    = {dStep_q[DW], dStep_q};
   assign gNEff     = (bus.g_npts == '0) ? NW'(1) : bus.g_npts;
   assign dNEff     = (bus.d_npts == '0) ? NW'(1) : bus.d_npts;
   assign gCode     = clampCode(gAcc_q);
   assign dCode     = clampCode(dAcc_q);
   assign gClip     = gAcc_q[CW-1] | gAcc_q[DW];
   assign dClip     = dAcc_q[CW-1] | dAcc_q[DW];
   assign lastInner = (di_q == innerLen_q - (NW+1)'(1));
   assign lastOuter = (gi_q == gNpts_q - NW'(1));
   assign innerFwd  = (di_q < ({1'b0, dNpts_q} - (NW+1)'(1)));

   // Next-state logic; abort overrides every transition of an active sweep.
   always_comb begin
      state_d    = state_q;
      gStep_d    = gStep_q;
      dStep_d    = dStep_q;
      gNpts_d    = gNpts_q;
      dNpts_d    = dNpts_q;
      innerLen_d = innerLen_q;
      dStart_d   = dStart_q;
      settle_d   = settle_q;
      cnt_d      = cnt_q;
      gAcc_d     = gAcc_q;
      dAcc_d     = dAcc_q;
      gi_d       = gi_q;
      di_d       = di_q;
      first_d    = first_q;
      vg_d       = vg_q;
      vd_d       = vd_q;
      dacUpd_d   = 1'b0;
      sat_d      = sat_q;
      resData_d  = resData_q;
      resGi_d    = resGi_q;
      resDi_d    = resDi_q;
      resLast_d  = resLast_q;

      if (bus.abort && state_q != IDLE && state_q != DONE) begin
         state_d = DONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  gStep_d    = bus.g_step;
                  dStep_d    = bus.d_step;
                  gNpts_d    = gNEff;
                  dNpts_d    = dNEff;
                  innerLen_d = bus.bidir ? ({dNEff, 1'b0} - (NW+1)'(1)) : {1'b0, dNEff};
                  dStart_d   = bus.d_start;
                  settle_d   = bus.settle_cyc;
                  gAcc_d     = {2'b00, bus.g_start};
                  dAcc_d     = {2'b00, bus.d_start};
                  gi_d       = '0;
                  di_d       = '0;
                  sat_d      = 1'b0;
                  first_d    = 1'b1;
                  state_d    = APPLY;
               end
            end
            APPLY: begin
               vg_d     = gCode;
               vd_d     = dCode;
               dacUpd_d = first_q | (gCode != vg_q) | (dCode != vd_q);
               sat_d    = sat_q | gClip | dClip;
               first_d  = 1'b0;
               cnt_d    = settle_q;
               state_d  = (settle_q == '0) ? MEAS : SETTLE;
            end
            SETTLE: begin
               if (cnt_q == SW'(1)) state_d = MEAS;
               else                 cnt_d   = cnt_q - SW'(1);
            end
            MEAS: begin
               if (bus.adc_ack) begin
                  resData_d = bus.adc_data;
                  resGi_d   = gi_q;
                  resDi_d   = di_q[NW-1:0];
                  resLast_d = lastOuter & lastInner;
                  state_d   = EMIT;
               end
            end
            EMIT: begin
               if (bus.res_ready) state_d = ADVANCE;
            end
            ADVANCE: begin
               if (lastInner) begin
                  di_d   = '0;
                  dAcc_d = {2'b00, dStart_q};
                  if (lastOuter) begin
                     state_d = DONE;
                  end else begin
                     gi_d    = gi_q + NW'(1);
                     gAcc_d  = gAcc_q + gStepX;
                     state_d = APPLY;
                  end
               end else begin
                  // Past the turn point the inner code retraces toward d_start.
                  di_d    = di_q + (NW+1)'(1);
                  dAcc_d  = innerFwd ? (dAcc_q + dStepX) : (dAcc_q - dStepX);
                  state_d = APPLY;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gStep_q    <= '0;
         dStep_q    <= '0;
         gNpts_q    <= '0;
         dNpts_q    <= '0;
         innerLen_q <= '0;
         dStart_q   <= '0;
         settle_q   <= '0;
         cnt_q      <= '0;
         gAcc_q     <= '0;
         dAcc_q     <= '0;
         gi_q       <= '0;
         di_q       <= '0;
         first_q    <= 1'b0;
         vg_q       <= '0;
         vd_q       <= '0;
         dacUpd_q   <= 1'b0;
         sat_q      <= 1'b0;
         resData_q  <= '0;
         resGi_q    <= '0;
         resDi_q    <= '0;
         resLast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gStep_q    <= gStep_d;
         dStep_q    <= dStep_d;
         gNpts_q    <= gNpts_d;
         dNpts_q    <= dNpts_d;
         innerLen_q <= innerLen_d;
         dStart_q   <= dStart_d;
         settle_q   <= settle_d;
         cnt_q      <= cnt_d;
         gAcc_q     <= gAcc_d;
         dAcc_q     <= dAcc_d;
         gi_q       <= gi_d;
         di_q       <= di_d;
         first_q    <= first_d;
         vg_q       <= vg_d;
         vd_q       <= vd_d;
         dacUpd_q   <= dacUpd_d;
         sat_q      <= sat_d;
         resData_q  <= resData_d;
         resGi_q    <= resGi_d;
         resDi_q    <= resDi_d;
         resLast_q  <= resLast_d;
      end
   end

   assign bus.vg_code   = vg_q;
   assign bus.vd_code   = vd_q;
   assign bus.dac_upd   = dacUpd_q;
   assign bus.adc_req   = (state_q == MEAS);
   assign bus.res_valid = (state_q == EMIT);
   assign bus.res_data  = resData_q;
   assign bus.res_gi    = resGi_q;
   assign bus.res_di    = resDi_q;
   assign bus.res_last  = resLast_q & (state_q == EMIT);
   assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
   assign bus.done      = (state_q == DONE);
   assign bus.sat       = sat_q;

endmodule
